// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   state_t          FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   DEF_CLKS_PER_BIT default bit period in clocks (25 MHz / 115200)
//   FRAME_BITS       serial bits per frame including start and stop
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DEF_CLKS_PER_BIT = 217;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-request / serial-line bundle of the UART transmitter.
//   i_Tx_DV      transmit request (source -> transmitter)
//   i_Tx_Byte    byte to send      (source -> transmitter)
//   o_Tx_Active  frame in progress (transmitter -> source)
//   o_Tx_Serial  serial TX line    (transmitter -> pad)
//   o_Tx_Done    completion pulse  (transmitter -> source)
// master: byte source side; slave: transmitter side.
interface uart_tx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: clock-per-bit counter for the UART transmitter.
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   clr      synchronous clear (held while the transmitter is idle)
//   bit_end  high during the last clock of each serial bit
// Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)   cnt <= '0;
    else if (bit_end) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per request, 8N1 LSB-first
// (8E1 when UART_TX_PARITY_EN is defined).
//   i_Clk   system clock, rising edge
//   i_Rst   synchronous active-high reset; abandons any frame, no Done
//   bus     uart_tx_if.slave: i_Tx_DV / i_Tx_Byte request,
//           o_Tx_Active / o_Tx_Serial / o_Tx_Done status
// Macro: UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
// All outputs are registered: the next-cycle values are derived from the
// next state so each output lines up with the state it describes.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  uart_tx_if.slave   bus
);

  state_t     state, state_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic       serial, serial_n;
  logic       active, active_n;
  logic       done, done_n;
  logic       bit_end;

  // Counter is held at zero while idle so START always gets a full bit.
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .clr     (state == IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      shift   <= '0;
      serial  <= 1'b1;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      serial  <= serial_n;
      active  <= active_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_Tx_DV) begin
          shift_n = bus.i_Tx_Byte;
          state_n = START;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          bit_idx_n = bit_idx + 3'd1;  // wraps to 0 after bit 7
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level for the cycle after this edge, taken from the next state.
    serial_n = 1'b1;
    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = shift_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_n = ^shift_n;  // even parity
`endif
      default: serial_n = 1'b1;
    endcase
    active_n = (state_n != IDLE);
  end

  assign bus.o_Tx_Serial = serial;
  assign bus.o_Tx_Active = active;
  assign bus.o_Tx_Done   = done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4.
// Every cycle of each frame is compared against a frame built from the byte.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C    = 4;
  localparam int FLEN = FRAME_BITS;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;
  int   last_done = 0;

  uart_tx_if tif ();

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (tif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller sets i_Tx_DV/i_Tx_Byte at a negedge, then calls this. Returns at the
  // negedge of the Done cycle (or of cycle abort_k), having checked every cycle.
  task automatic expect_frame(input logic [7:0] b, input int inj_k, input int abort_k,
                              input string tag);
    logic [10:0] fb;
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, ^b, b, 1'b0};
`else
    fb = {1'b1, 1'b1, b, 1'b0};
`endif
    @(negedge clk);
    tif.i_Tx_DV   = 1'b0;
    tif.i_Tx_Byte = ~b;
    for (int k = 1; k <= FLEN * C; k++) begin
      if (k == inj_k) begin
        tif.i_Tx_DV   = 1'b1;
        tif.i_Tx_Byte = 8'h3C;
      end else if (k == inj_k + 1) begin
        tif.i_Tx_DV = 1'b0;
      end
      chk($sformatf("%s_ser_c%0d", tag, k), tif.o_Tx_Serial, fb[(k-1)/C]);
      chk($sformatf("%s_act_c%0d", tag, k), tif.o_Tx_Active, 1);
      chk($sformatf("%s_done_c%0d", tag, k), tif.o_Tx_Done, 0);
      if (k == abort_k) return;
      @(negedge clk);
    end
    chk({tag, "_done"}, tif.o_Tx_Done, 1);
    chk({tag, "_done_act"}, tif.o_Tx_Active, 0);
    chk({tag, "_done_ser"}, tif.o_Tx_Serial, 1);
    last_done = cyc;
  endtask

  initial begin
    int s, d1, ndone;
    rst = 1'b1;
    tif.i_Tx_DV   = 1'b0;
    tif.i_Tx_Byte = 8'h00;

    // Reset held for 3 cycles, then idle line
    repeat (3) @(negedge clk);
    chk("rst_ser", tif.o_Tx_Serial, 1);
    chk("rst_act", tif.o_Tx_Active, 0);
    chk("rst_done", tif.o_Tx_Done, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ser%0d", i), tif.o_Tx_Serial, 1);
      chk($sformatf("idle_act%0d", i), tif.o_Tx_Active, 0);
    end

    // Single frame 0xA5
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'hA5; s = cyc;
    expect_frame(8'hA5, -1, -1, "a5");
    chk("a5_done_time", last_done - s, FLEN * C + 1);
    @(negedge clk);
    chk("a5_done_pulse_end", tif.o_Tx_Done, 0);

    // Back-to-back: second request in the Done cycle
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'h00;
    expect_frame(8'h00, -1, -1, "b2b0");
    d1 = last_done;
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'hFF;
    expect_frame(8'hFF, -1, -1, "b2bF");
    chk("b2b_done_gap", last_done - d1, FLEN * C + 1);
    @(negedge clk);
    chk("b2b_done_end", tif.o_Tx_Done, 0);

    // Request mid-DATA is ignored and not queued
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'h55;
    expect_frame(8'h55, 2 * C + 2, -1, "busy");
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      chk($sformatf("busy_noframe_act%0d", i), tif.o_Tx_Active, 0);
      chk($sformatf("busy_noframe_ser%0d", i), tif.o_Tx_Serial, 1);
    end

    // Reset during data bit 3
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'hC3;
    expect_frame(8'hC3, -1, 4 * C + 2, "abort");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ser", tif.o_Tx_Serial, 1);
    chk("abort_act", tif.o_Tx_Active, 0);
    ndone = 0;
    for (int i = 0; i < 12 * C; i++) begin
      if (tif.o_Tx_Done === 1'b1 || tif.o_Tx_Serial !== 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done_quiet_line", ndone, 0);
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'h96;
    expect_frame(8'h96, -1, -1, "after_abort");

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    tif.i_Tx_DV = 1'b1; tif.i_Tx_Byte = 8'h07; s = cyc;
    expect_frame(8'h07, -1, -1, "par07");
    chk("par07_done_time", last_done - s, 45);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per request onto the RS-232 TX line as 8N1 (start, 8 data LSB-first, stop). It produces the `o_Tx_Done` completion pulse consumed by the data-select logic, which uses it to present the next byte. It sits between the byte source and the TX pad buffer.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per serial bit (25 MHz / 115200); legal range 2..65535.
- `i_Clk`  in  1  system clock, all logic on rising edge.
- `i_Rst`  in  1  reset, synchronous, active-high.
- `i_Tx_DV`  in  1  transmit request; sampled only in IDLE.
- `i_Tx_Byte`  in  8  byte to send; captured on the cycle `i_Tx_DV` is accepted.
- `o_Tx_Active`  out  1  high from start bit through stop bit.
- `o_Tx_Serial`  out  1  serial line, idle high.
- `o_Tx_Done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP (PARITY added under the macro).
- Reset (`i_Rst` high at a rising edge): state IDLE, `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, bit counter 0, clock counter 0. Applies mid-frame: the frame is abandoned, the line returns high the next cycle, and no Done pulse is issued.
- IDLE: `o_Tx_Serial`=1. If `i_Tx_DV`=1, latch `i_Tx_Byte` to the shift register and go to START.
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive `shift[bit_idx]`, bit_idx 0..7 (LSB first), each held CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY).
- STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE and assert `o_Tx_Done` for exactly that one cycle.
- `i_Tx_DV` outside IDLE is ignored; no queueing. Changes to `i_Tx_Byte` after capture have no effect.
- Clock counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It wraps to 0 on each bit boundary. The bit index is 3 bits and wraps after 7.

## Timing
- Request accepted at edge N → `o_Tx_Serial`=0 and `o_Tx_Active`=1 from cycle N+1.
- Start bit: cycles N+1..N+C (C=CLKS_PER_BIT).
- Data bit k: cycles N+1+(k+1)C .. N+(k+2)C.
- Stop bit: cycles N+1+9C .. N+10C.
- `o_Tx_Done`=1 only in cycle N+10C+1. In that cycle `o_Tx_Active`=0, `o_Tx_Serial`=1, and the state is IDLE.
- Simultaneous Done and new request: a `i_Tx_DV` sampled at the end of the Done cycle is accepted. This gives back-to-back frames with one idle-high cycle between stop and start.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state follows DATA. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11C; Done moves to cycle N+11C+1.
- Undefined: no PARITY state, 8N1, timing as above.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), default CLKS_PER_BIT, frame bit count.
- One natural sub-module: `uart_baud_cnt`, the clock-per-bit counter with synchronous clear and a `bit_end` strobe. The FSM and shift register stay in `uart_tx`.

## Test plan
- Reset: hold `i_Rst` 3 cycles → Serial=1, Active=0, Done=0; Serial stays 1 with no request.
- Single frame, C=4, byte 0xA5: start 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, stop 1. Done pulses in cycle N+41 only.
- Back-to-back, 0x00 then 0xFF with the second DV in the Done cycle: exactly one high cycle between the first stop and the second start. Two Done pulses, 41 cycles apart.
- Busy ignore: DV with 0x3C pulsed mid-DATA of frame 0x55 → frame 0x55 is unchanged and no extra frame follows.
- Mid-frame reset during data bit 3: Serial=1 and Active=0 the cycle after reset; Done is never asserted; the next request transmits normally.
- With `UART_TX_PARITY_EN`, byte 0x07: parity bit 1 appears after bit 7; Done arrives at N+45 with C=4.
